// File: rtl/stream_accumulator.sv
// Sums ACC_LEN consecutive input words into one widened total and presents it,
// with its item count, on a valid/ready output; flush closes a partial group early.
module stream_accumulator #(
  parameter int DW      = 32,
  parameter int ACC_LEN = 4,
  localparam int OW     = (ACC_LEN == 1) ? DW : DW + $clog2(ACC_LEN),
  localparam int CW     = $clog2(ACC_LEN + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [OW-1:0] out_data,
  output logic [CW-1:0] out_cnt,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  localparam logic [CW-1:0] LEN_C = CW'(ACC_LEN);

  state_e        state_q, state_d;
  logic [OW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  logic [OW-1:0] acc_n;
  logic [CW-1:0] cnt_n;
  logic          in_fire;
  logic          out_fire;

  // While a total is held, a new item may only enter in the same cycle the total leaves.
  assign in_ready  = rstn & ((state_q == ST_ACC) | out_ready);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_cnt_d  = out_cnt_q;
    acc_n      = acc_q + OW'(in_data);
    cnt_n      = cnt_q + CW'(1);

    unique case (state_q)
      ST_ACC: begin
        if (in_fire) begin
          if (cnt_n == LEN_C || flush) begin
            out_data_d = acc_n;
            out_cnt_d  = cnt_n;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = ST_OUT;
          end else begin
            acc_d = acc_n;
            cnt_d = cnt_n;
          end
        end else if (flush && cnt_q != '0) begin
          out_data_d = acc_q;
          out_cnt_d  = cnt_q;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = ST_OUT;
        end
      end

      ST_OUT: begin
        if (out_fire) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACC;
          if (in_fire) begin
            // A single-item group closes immediately, so skip the ACC cycle entirely.
            if (ACC_LEN == 1 || flush) begin
              out_data_d = OW'(in_data);
              out_cnt_d  = CW'(1);
              state_d    = ST_OUT;
            end else begin
              acc_d = OW'(in_data);
              cnt_d = CW'(1);
            end
          end
        end
      end

      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

endmodule
